// File: rtl/sequence_multiplier.sv
// sequence_multiplier
//
// Consumer end of the gate-sequence interface driven by sequence_generator.
// Gates arrive one per handshake, highest index first. Each gate's 2x2
// complex fixed-point matrix is read from an external combinational table
// (addressed by seq_gate) and right-multiplied into an accumulator:
// acc = acc * G. The final product G[n-1] * ... * G[0] is presented with a
// one-cycle result_valid pulse once index 0 has been absorbed.
//
// Matrix packing, MSB to LSB:
//   {m00re, m00im, m01re, m01im, m10re, m10im, m11re, m11im}
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   seq_index    index of the offered gate
//   seq_gate     gate id (drives the external table address)
//   ready        generator is offering a gate
//   first        offered gate starts a new sequence (load, no multiply)
//   available    high when able to accept a gate (registered)
//   gate_matrix  matrix for seq_gate from the external table
//   result       product matrix (registered)
//   result_valid one-cycle pulse when result is updated
//
// Optional build macro:
//   SEQ_MULT_SATURATE_EN  clamp rounded entries to the signed WIDTH range;
//                         when undefined the low WIDTH bits are kept (wrap).

module sequence_multiplier #(
  parameter int WIDTH          = 16,
  parameter int FRAC           = 14,
  parameter int SEQ_INDEX_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEQ_INDEX_BITS-1:0] seq_index,
  input  logic [4:0]                seq_gate,
  input  logic                      ready,
  input  logic                      first,
  output logic                      available,
  input  logic [8*WIDTH-1:0]        gate_matrix,
  output logic [8*WIDTH-1:0]        result,
  output logic                      result_valid
);

  // Full-precision width for the sum of two complex-product components
  localparam int PW = 2 * WIDTH + 2;

  localparam logic signed [PW-1:0] HALF =
    {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

`ifdef SEQ_MULT_SATURATE_EN
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, LOAD, MULT, COMMIT} state_t;

  state_t state_q, state_d;

  logic                  avail_q;
  logic                  avail_prev_q;
  logic                  valid_q;
  logic                  last_q;
  logic [2:0]            k_q;
  logic [8*WIDTH-1:0]    g_q;
  logic [8*WIDTH-1:0]    acc_q;
  logic [8*WIDTH-1:0]    tmp_out_q;
  logic [8*WIDTH-1:0]    result_q;
  logic signed [PW-1:0]  tmp_re_q, tmp_im_q;

  logic accept;

  // Accept needs a full cycle of available already behind us: the generator
  // updates its index one cycle after it sees available rise, so sampling in
  // the rise cycle itself would pick up a stale index.
  assign accept = ready && (state_q == IDLE) && avail_q && avail_prev_q;

  assign available    = avail_q;
  assign result_valid = valid_q;
  assign result       = result_q;

  // Next-state logic. LOAD and COMMIT are single-cycle; MULT walks k 0..7.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = first ? LOAD : MULT;
      LOAD:    state_d = IDLE;
      MULT:    if (k_q == 3'd7) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unpack accumulator and latched gate into per-entry components.
  // Entry n = 2*row + col; its real part sits at slot 7-2n from the LSB.
  logic signed [WIDTH-1:0] acc_re [4];
  logic signed [WIDTH-1:0] acc_im [4];
  logic signed [WIDTH-1:0] g_re   [4];
  logic signed [WIDTH-1:0] g_im   [4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      acc_re[n] = acc_q[(7 - 2*n)*WIDTH +: WIDTH];
      acc_im[n] = acc_q[(6 - 2*n)*WIDTH +: WIDTH];
      g_re[n]   = g_q[(7 - 2*n)*WIDTH +: WIDTH];
      g_im[n]   = g_q[(6 - 2*n)*WIDTH +: WIDTH];
    end
  end

  // k[2:1] picks output entry (r,c), k[0] picks the inner term j:
  // the operands are acc(r,j) and G(j,c).
  logic [1:0] a_idx, b_idx, o_idx;
  assign a_idx = {k_q[2], k_q[0]};
  assign b_idx = {k_q[0], k_q[1]};
  assign o_idx = {k_q[2], k_q[1]};

  logic signed [WIDTH-1:0]   a_re, a_im, b_re, b_im;
  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]      term_re, term_im;
  logic signed [PW-1:0]      sum_re, sum_im;
  logic signed [PW-1:0]      rsum_re, rsum_im;
  logic signed [PW-1:0]      rnd_re, rnd_im;
  logic [WIDTH-1:0]          out_re, out_im;
  int                        o_lsb_re, o_lsb_im;

  // One complex product per cycle, then round-half-up on the second term.
  always_comb begin
    a_re    = acc_re[a_idx];
    a_im    = acc_im[a_idx];
    b_re    = g_re[b_idx];
    b_im    = g_im[b_idx];
    p_rr    = a_re * b_re;
    p_ii    = a_im * b_im;
    p_ri    = a_re * b_im;
    p_ir    = a_im * b_re;
    term_re = {{2{p_rr[2*WIDTH-1]}}, p_rr} - {{2{p_ii[2*WIDTH-1]}}, p_ii};
    term_im = {{2{p_ri[2*WIDTH-1]}}, p_ri} + {{2{p_ir[2*WIDTH-1]}}, p_ir};
    sum_re  = tmp_re_q + term_re;
    sum_im  = tmp_im_q + term_im;
    rsum_re = sum_re + HALF;
    rsum_im = sum_im + HALF;
    rnd_re  = rsum_re >>> FRAC;
    rnd_im  = rsum_im >>> FRAC;
    o_lsb_re = (7 - 2*int'(o_idx)) * WIDTH;
    o_lsb_im = (6 - 2*int'(o_idx)) * WIDTH;
  end

  // Narrow rounded entries back to WIDTH bits.
`ifdef SEQ_MULT_SATURATE_EN
  always_comb begin
    if (rnd_re > SAT_MAX)      out_re = SAT_MAX[WIDTH-1:0];
    else if (rnd_re < SAT_MIN) out_re = SAT_MIN[WIDTH-1:0];
    else                       out_re = rnd_re[WIDTH-1:0];
    if (rnd_im > SAT_MAX)      out_im = SAT_MAX[WIDTH-1:0];
    else if (rnd_im < SAT_MIN) out_im = SAT_MIN[WIDTH-1:0];
    else                       out_im = rnd_im[WIDTH-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^seq_gate;
`else
  always_comb begin
    out_re = rnd_re[WIDTH-1:0];
    out_im = rnd_im[WIDTH-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{seq_gate, rnd_re[PW-1:WIDTH], rnd_im[PW-1:WIDTH]};
`endif

  // Control registers. available tracks the state being entered, so it is
  // low for the reset cycle and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      avail_q      <= 1'b0;
      avail_prev_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      avail_q      <= (state_d == IDLE);
      avail_prev_q <= avail_q;
      valid_q      <= ((state_q == LOAD) || (state_q == COMMIT)) && last_q;
    end
  end

  // Datapath: latch the gate on accept, load or multiply into acc, and
  // publish the new acc when the index-0 gate finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q       <= '0;
      acc_q     <= '0;
      tmp_out_q <= '0;
      tmp_re_q  <= '0;
      tmp_im_q  <= '0;
      result_q  <= '0;
      last_q    <= 1'b0;
      k_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            g_q    <= gate_matrix;
            last_q <= (seq_index == '0);
            k_q    <= '0;
          end
        end
        LOAD: begin
          acc_q <= g_q;
          if (last_q) result_q <= g_q;
        end
        MULT: begin
          k_q <= k_q + 3'd1;
          if (!k_q[0]) begin
            tmp_re_q <= term_re;
            tmp_im_q <= term_im;
          end else begin
            tmp_out_q[o_lsb_re +: WIDTH] <= out_re;
            tmp_out_q[o_lsb_im +: WIDTH] <= out_im;
          end
        end
        COMMIT: begin
          acc_q <= tmp_out_q;
          if (last_q) result_q <= tmp_out_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_multiplier.sv
// Directed testbench for sequence_multiplier. Each scenario task drives
// gates through the handshake and compares timing and the product matrix
// against hand-computed values.

module tb_sequence_multiplier;

  localparam int WIDTH = 16;
  localparam int SIB   = 5;
  localparam int MW    = 8 * WIDTH;

  logic           clk;
  logic           reset;
  logic [SIB-1:0] seq_index;
  logic [4:0]     seq_gate;
  logic           ready;
  logic           first;
  logic           available;
  logic [MW-1:0]  gate_matrix;
  logic [MW-1:0]  result;
  logic           result_valid;

  int checks = 0;
  int errors = 0;

  sequence_multiplier #(.WIDTH(16), .FRAC(14), .SEQ_INDEX_BITS(SIB)) dut (
    .clk          (clk),
    .reset        (reset),
    .seq_index    (seq_index),
    .seq_gate     (seq_gate),
    .ready        (ready),
    .first        (first),
    .available    (available),
    .gate_matrix  (gate_matrix),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mat(
    input logic [15:0] e0, input logic [15:0] e1,
    input logic [15:0] e2, input logic [15:0] e3,
    input logic [15:0] e4, input logic [15:0] e5,
    input logic [15:0] e6, input logic [15:0] e7);
    return {e0, e1, e2, e3, e4, e5, e6, e7};
  endfunction

  logic [MW-1:0] ident, xgate, hgate, sgate, igate, agate, bgate;

  // Offer a gate once available has been high for a full cycle, hold ready
  // over one rising edge, then withdraw it.
  task automatic send_gate(input logic [SIB-1:0] idx, input logic [4:0] gid,
                           input logic [MW-1:0] m, input logic f);
    int n = 0;
    while (available !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (available !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_wait: available=%b after %0d cycles, required 1", available, n);
    end
    @(negedge clk);
    seq_index   = idx;
    seq_gate    = gid;
    gate_matrix = m;
    first       = f;
    ready       = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Called just after the accept edge; counts cycles until result_valid.
  task automatic wait_result(output int lat, output logic [MW-1:0] res,
                             output logic avail_a1, output logic avail_at,
                             output logic pulse_after);
    lat      = 0;
    avail_a1 = 1'bx;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) avail_a1 = available;
    end while (result_valid !== 1'b1 && lat < 20);
    avail_at = available;
    res      = result;
    @(negedge clk);
    pulse_after = result_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b1; first = 1'b1; seq_index = '0;
    seq_gate = 5'd1; gate_matrix = ident;
    repeat (3) @(negedge clk);
    checks++;
    if (available !== 1'b0) begin errors++; $display("[TB] FAIL reset_available: got %b, required 0", available); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", result_valid); end
    checks++;
    if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h, required 0", result); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (available !== 1'b1) begin errors++; $display("[TB] FAIL release_available: got %b, required 1", available); end
    @(negedge clk);
    checks++;
    if (available !== 1'b1) begin errors++; $display("[TB] FAIL accept_guard: available=%b, required 1 (no accept yet)", available); end
    @(negedge clk);
    checks++;
    if (available !== 1'b0) begin errors++; $display("[TB] FAIL guarded_accept: available=%b, required 0", available); end
    ready = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result !== ident) begin
      errors++;
      $display("[TB] FAIL reset_first_result: valid=%b result=%h, required 1 %h", result_valid, result, ident);
    end
    @(negedge clk);
  endtask

  task automatic test_length1();
    int lat; logic [MW-1:0] res; logic a1, at, pa;
    send_gate(0, 5'd1, ident, 1'b1);
    wait_result(lat, res, a1, at, pa);
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL len1_latency: got %0d, required 2", lat); end
    checks++;
    if (a1 !== 1'b0) begin errors++; $display("[TB] FAIL len1_busy: available=%b at A+1, required 0", a1); end
    checks++;
    if (at !== 1'b1) begin errors++; $display("[TB] FAIL len1_avail_rise: got %b, required 1", at); end
    checks++;
    if (res !== ident) begin errors++; $display("[TB] FAIL len1_result: got %h, required %h", res, ident); end
    checks++;
    if (pa !== 1'b0) begin errors++; $display("[TB] FAIL len1_pulse_width: valid=%b next cycle, required 0", pa); end
  endtask

  // Two-gate sequence; the index-1 gate must not produce a result.
  task automatic run_pair(input string name, input logic [MW-1:0] g1,
                          input logic [MW-1:0] g0, input logic [MW-1:0] expv);
    int lat; logic [MW-1:0] res; logic a1, at, pa;
    bit seen = 0;
    send_gate(1, 5'd2, g1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL %s_early_valid: got 1, required 0", name); end
    send_gate(0, 5'd3, g0, 1'b0);
    wait_result(lat, res, a1, at, pa);
    checks++;
    if (lat != 10) begin errors++; $display("[TB] FAIL %s_latency: got %0d, required 10", name, lat); end
    checks++;
    if (at !== 1'b1 || a1 !== 1'b0) begin errors++; $display("[TB] FAIL %s_available: A+1=%b rise=%b, required 0 1", name, a1, at); end
    checks++;
    if (res !== expv) begin errors++; $display("[TB] FAIL %s_result: got %h, required %h", name, res, expv); end
    checks++;
    if (pa !== 1'b0) begin errors++; $display("[TB] FAIL %s_pulse_width: got %b, required 0", name, pa); end
  endtask

  task automatic test_xx();
    run_pair("xx", xgate, xgate, ident);
  endtask

  task automatic test_hh();
    run_pair("hh", hgate, hgate, mat(16'h3FFF, 0, 0, 0, 0, 0, 16'h3FFF, 0));
  endtask

  task automatic test_saturate();
`ifdef SEQ_MULT_SATURATE_EN
    run_pair("sat", sgate, sgate, mat(16'h7FFF, 0, 0, 0, 0, 0, 16'h4000, 0));
`else
    run_pair("sat", sgate, sgate, mat(16'hFFFC, 0, 0, 0, 0, 0, 16'h4000, 0));
`endif
  endtask

  task automatic test_complex();
    run_pair("ii", igate, igate, mat(16'hC000, 0, 0, 0, 0, 0, 16'hC000, 0));
    run_pair("ab", agate, bgate, mat(0, 16'h4000, 0, 16'h2000, 0, 16'h4000, 0, 0));
  endtask

  task automatic test_handshake();
    bit drop = 0;
    bit pulse = 0;
    ready = 1'b0; first = 1'b1; seq_index = '0; gate_matrix = ident;
    repeat (10) begin
      @(negedge clk);
      if (available !== 1'b1) drop = 1;
      if (result_valid !== 1'b0) pulse = 1;
    end
    checks++;
    if (drop) begin errors++; $display("[TB] FAIL idle_available: dropped while ready=0, required steady 1"); end
    checks++;
    if (pulse) begin errors++; $display("[TB] FAIL idle_valid: pulse while ready=0, required none"); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [MW-1:0] res; logic a1, at, pa;
    bit seen = 0;
    send_gate(0, 5'd1, ident, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (available !== 1'b0) begin errors++; $display("[TB] FAIL midreset_available: got %b, required 0", available); end
    checks++;
    if (result !== '0) begin errors++; $display("[TB] FAIL midreset_result: got %h, required 0", result); end
    repeat (2) begin
      @(negedge clk);
      if (result_valid !== 1'b0) seen = 1;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (result_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL midreset_valid: lost gate produced a pulse, required none"); end
    // Non-first gate straight after reset multiplies into a zero accumulator.
    send_gate(0, 5'd1, ident, 1'b0);
    wait_result(lat, res, a1, at, pa);
    checks++;
    if (lat != 10 || res !== '0) begin errors++; $display("[TB] FAIL nofirst_result: lat=%0d result=%h, required 10 0", lat, res); end
    send_gate(0, 5'd1, ident, 1'b1);
    wait_result(lat, res, a1, at, pa);
    checks++;
    if (lat != 2 || res !== ident) begin errors++; $display("[TB] FAIL postreset_len1: lat=%0d result=%h, required 2 %h", lat, res, ident); end
  endtask

  initial begin
    ident = mat(16'h4000, 0, 0, 0, 0, 0, 16'h4000, 0);
    xgate = mat(0, 0, 16'h4000, 0, 16'h4000, 0, 0, 0);
    hgate = mat(16'h2D41, 0, 16'h2D41, 0, 16'h2D41, 0, 16'hD2BF, 0);
    sgate = mat(16'h7FFF, 0, 0, 0, 0, 0, 16'h4000, 0);
    igate = mat(0, 16'h4000, 0, 0, 0, 0, 0, 16'h4000);
    agate = mat(0, 16'h4000, 0, 0, 0, 0, 16'h4000, 0);
    bgate = mat(16'h4000, 0, 16'h2000, 0, 0, 16'h4000, 0, 0);
    test_reset();
    test_length1();
    test_xx();
    test_hh();
    test_saturate();
    test_complex();
    test_handshake();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sequence_multiplier.md
# sequence_multiplier

- Consumer end of the gate-sequence interface driven by `sequence_generator`.
- Accepts one gate per handshake, highest index first, and looks up the gate's 2×2 complex fixed-point matrix on an external combinational table bus.
- Right-multiplies the matrix into an accumulator: acc = acc·G, so the final result is G[n-1]·…·G[0].
- When index 0 has been absorbed, presents the product with a one-cycle valid pulse.

## Interface

Parameters:

- WIDTH, 16, signed component width (real and imag)
- FRAC, 14, fractional bits; 1.0 = 1<<FRAC
- SEQ_INDEX_BITS, from types.svi, seq_index width

Ports:

- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- seq_index  in  SEQ_INDEX_BITS  index of the offered gate
- seq_gate  in  5  gate id; also drives the external matrix table address
- ready  in  1  generator offering a gate
- first  in  1  offered gate starts a new sequence (load, don't multiply)
- available  out  1  high when able to accept a gate
- gate_matrix  in  8*WIDTH  matrix for seq_gate, packed MSB→LSB {m00re,m00im,m01re,m01im,m10re,m10im,m11re,m11im}, combinational
- result  out  8*WIDTH  product matrix, same packing
- result_valid  out  1  one-cycle pulse, result updated

## Operation

- States: IDLE, LOAD, MULT, COMMIT.
- **IDLE**
  - available=1.
  - Accept requires all of: ready=1, IDLE in the current cycle, and IDLE in the previous cycle. This guards against resampling the stale index the generator updates one cycle after the available rise.
  - On accept, latch gate_matrix into G and set last := (seq_index==0).
  - Go to LOAD if first=1, else MULT.
- **LOAD** (1 cycle): acc ← G → IDLE.
- **MULT** (8 cycles, counter k=0..7)
  - One complex product per cycle: entry (r,c) = k[2:1] selects the entry, k[0] selects the term j.
  - tmp(r,c) accumulates acc(r,j)·G(j,c) at full precision (2·WIDTH+2 bits).
  - At j=1, round the entry: add 1<<(FRAC-1), arithmetic shift right by FRAC, then narrow to WIDTH per Configuration. Store in tmp_out(r,c).
- **COMMIT** (1 cycle): acc ← tmp_out → IDLE.
- **Last gate:** on leaving LOAD or COMMIT with last=1, result ← new acc and result_valid=1 for exactly one cycle. This is the same cycle available rises.
- Inputs are ignored outside IDLE. ready is sampled only at accept. ready dropping while busy has no effect.
- first=1 always discards acc regardless of history. Length-1 sequences (first=1, index 0) produce result=G.
- A non-first gate before any first multiplies with acc=0.
- Reset, async and at any time, including mid-MULT:
  - acc, tmp, G, k, result: 0.
  - available=0, result_valid=0, state=IDLE.
  - The in-flight gate is lost.

## Timing

- Outputs are registered except nothing combinational to outputs.
- available=1 from the first clk edge after reset deasserts.
- Accept at cycle A:
  - available=0 at A+1.
  - First gate: IDLE again (available=1) at A+2.
  - Other gates: MULT A+1..A+8, COMMIT A+9, available=1 at A+10.
- result_valid coincides with that available rise (A+2 or A+10).
- The earliest next accept is one cycle after available rises.

## Configuration

- SEQ_MULT_SATURATE_EN defined: rounded entries are clamped to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- Not defined: the low WIDTH bits are kept (two's-complement wrap). This saves the comparators.

## Test plan

1. **Reset.** Hold reset=0 with ready=1 → available=0, result_valid=0, result=0. Release → available=1 after the first edge; no accept occurs until available has been high for one full cycle.
2. **Length 1.** first=1, seq_index=0, identity (m00re=m11re=0x4000, others 0), accept at A → result_valid at A+2, result=identity, available=1 at A+2.
3. **X·X.** Index 1 X (m01re=m10re=0x4000, first=1), then index 0 X → after second accept A2, result_valid at A2+10, result=identity.
4. **H·H.** All four real entries ±0x2D41 (m11re=-0x2D41), two gates → diagonals 0x3FFF, off-diagonals 0x0000 and all imag 0. Checks round-half-up.
5. **Saturation.** diag(0x7FFF, 0x4000) twice → m00re=0x7FFF with SEQ_MULT_SATURATE_EN, 0xFFFC without; m11re=0x4000 either way.
6. **Handshake and mid-sequence reset.**
   - ready=0 in IDLE for 10 cycles → no accept, available stays 1.
   - Assert reset at A+4 of a MULT → available=0 immediately, no result_valid.
   - After release, a length-1 identity sequence yields identity.
